// File: rtl/ff_apb_pkg.sv
// Shared types and default widths for the two-requester APB master.
package ff_apb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // One-hot decode of a requester index.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ff_rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational, the last-grant
// state is held by the parent.
module ff_rr_arbiter2 (
    input  logic       req0_valid_i,
    input  logic       req1_valid_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req0_valid_i && req1_valid_i) begin
                // Contention: the requester not served last time wins.
                grant_o = last_grant_i ? 2'b01 : 2'b10;
            end else if (req0_valid_i) begin
                grant_o = 2'b01;
            end else if (req1_valid_i) begin
                grant_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/ff_apb_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS
// sequencing with no pready, one-cycle done pulse and per-requester read data.
module ff_apb_arbiter
    import ff_apb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,

    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              gidx_q, gidx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        grant;
    logic              arb_en;
    logic              accept;
    logic              read_done;

    // Arbitration is gated off while reset is high so ready never leaks out.
    assign arb_en = (state_q != ST_SETUP) && !reset;
    assign accept = |grant;

    ff_rr_arbiter2 u_rr (
        .req0_valid_i (req0_valid),
        .req1_valid_i (req1_valid),
        .last_grant_i (last_q),
        .en_i         (arb_en),
        .grant_o      (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = accept ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = accept ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d   = last_q;
        gidx_d   = gidx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (accept) begin
            last_d   = grant[1];
            gidx_d   = grant[1];
            paddr_d  = grant[1] ? req1_addr  : req0_addr;
            pwrite_d = grant[1] ? req1_write : req0_write;
            pwdata_d = grant[1] ? req1_wdata : req0_wdata;
        end
    end

    // Completion is registered off the ACCESS cycle, so done lands one cycle later.
    always_comb begin
        done_d    = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        read_done = (state_q == ST_ACCESS) && !pwrite_q;
        if (state_q == ST_ACCESS) begin
            done_d = idx_to_onehot(gidx_q);
        end
        if (read_done && !gidx_q) begin
            rdata0_d = prdata;
        end
        if (read_done && gidx_q) begin
            rdata1_d = prdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gidx_q   <= 1'b0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            done_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gidx_q   <= gidx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign psel       = (state_q != ST_IDLE);
    assign penable    = (state_q == ST_ACCESS);
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule
